dmem_boot_loader: RTL and testbench

//   Boot-time sequencer for the single-cycle core's data memory preload path.

---
 rtl/dmem_boot_loader_pkg.sv | 14 +
 rtl/dmem_boot_loader_word_packer.sv | 35 +++
 rtl/dmem_boot_loader.sv | 103 ++++++++++
 tb/tb_dmem_boot_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_boot_loader_pkg.sv
// Shared definitions for the data-memory boot loader: FSM encoding and byte-lane sizing.
package dmem_boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loaderState_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/dmem_boot_loader_word_packer.sv
// Packs accepted host bytes little-endian into a 32-bit word; full flags the last lane.
module word_packer
  import dmem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        full
);

  logic [LANE_IDX_W-1:0] byteIdx;
  logic [31:0]           lanes;

  // word already includes the byte being pushed, so the loader can latch it on the same edge
  always_comb begin
    word = lanes;
    if (push) word[{byteIdx, 3'b000} +: 8] = byte_data;
  end

  assign full = push && (byteIdx == LANE_IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      byteIdx <= '0;
      lanes   <= '0;
    end else if (push) begin
      byteIdx <= byteIdx + 1'b1;
      lanes   <= word;
    end
  end

endmodule

// File: rtl/dmem_boot_loader.sv
// Boot-time sequencer: holds the CPU in reset while a host byte stream is packed
// into words and written to data memory, then releases the CPU.
//
// state   | meaning
// IDLE    | waiting for start, CPU held in reset
// COLLECT | accepting bytes into the packer
// WRITE   | one-cycle write strobe for the assembled word
// DONE    | image written, CPU released, bytes ignored
module dmem_boot_loader
  import dmem_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done
);

  localparam int WIDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  loaderState_t      state;
  logic [WIDX_W-1:0] wordIdx;
  logic [31:0]       packWord;
  logic              packFull;
  logic              packClr;
  logic              push;
  logic [31:0]       wordOffset;

  assign push       = byte_valid && byte_ready;
  assign packClr    = start && ((state == IDLE) || (state == DONE));
  assign wordOffset = {{(30 - WIDX_W){1'b0}}, wordIdx, 2'b00};

  word_packer uPacker (
    .clk      (clk),
    .reset    (reset),
    .clr      (packClr),
    .push     (push),
    .byte_data(byte_data),
    .word     (packWord),
    .full     (packFull)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wordIdx       <= '0;
      cpu_reset     <= 1'b1;
      byte_ready    <= 1'b0;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= BASE_ADDR;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            wordIdx    <= '0;
            cpu_reset  <= 1'b1;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        COLLECT: begin
          if (packFull) begin
            state         <= WRITE;
            byte_ready    <= 1'b0;
            Ext_MemWrite  <= 1'b1;
            Ext_WriteData <= packWord;
            Ext_DataAdr   <= BASE_ADDR + wordOffset;
          end
        end
        WRITE: begin
          Ext_MemWrite <= 1'b0;
          if (wordIdx == WIDX_W'(WORD_COUNT - 1)) begin
            state     <= DONE;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state      <= COLLECT;
            wordIdx    <= wordIdx + 1'b1;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Directed bench: a single-word loader (A) and a four-word loader at 0x100 (B).
module tb_dmem_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aReset, aStart, aValid, aReady, aCpuReset, aMemWrite, aBusy, aDone;
  logic [7:0]  aData;
  logic [31:0] aWriteData, aDataAdr;
  logic bReset, bStart, bValid, bReady, bCpuReset, bMemWrite, bBusy, bDone;
  logic [7:0]  bData;
  logic [31:0] bWriteData, bDataAdr;

  dmem_boot_loader #(.BASE_ADDR(32'h0000_0000), .WORD_COUNT(1)) dutA (
    .clk(clk), .reset(aReset), .start(aStart), .byte_valid(aValid), .byte_data(aData),
    .byte_ready(aReady), .cpu_reset(aCpuReset), .Ext_MemWrite(aMemWrite),
    .Ext_WriteData(aWriteData), .Ext_DataAdr(aDataAdr), .busy(aBusy), .done(aDone)
  );

  dmem_boot_loader #(.BASE_ADDR(32'h0000_0100), .WORD_COUNT(4)) dutB (
    .clk(clk), .reset(bReset), .start(bStart), .byte_valid(bValid), .byte_data(bData),
    .byte_ready(bReady), .cpu_reset(bCpuReset), .Ext_MemWrite(bMemWrite),
    .Ext_WriteData(bWriteData), .Ext_DataAdr(bDataAdr), .busy(bBusy), .done(bDone)
  );

  int vectors = 0;
  int miscompares = 0;
  int aStrobes = 0;
  logic [31:0] bAdrQ[$];
  logic [31:0] bDatQ[$];
  int gapTab[16] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 4, 1, 0, 2, 0, 0, 1};

  always @(negedge clk) begin
    if (aMemWrite === 1'b1) aStrobes++;
    if (bMemWrite === 1'b1) begin
      bAdrQ.push_back(bDataAdr);
      bDatQ.push_back(bWriteData);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte after gap idle cycles and hold it until the loader takes it.
  task automatic sendByte(input bit useB, input logic [7:0] b, input int gap);
    bit ok;
    int n;
    repeat (gap) tick();
    if (useB) begin bValid = 1'b1; bData = b; end
    else begin aValid = 1'b1; aData = b; end
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      ok = useB ? bReady : aReady;
      tick();
      n++;
    end
    if (useB) bValid = 1'b0; else aValid = 1'b0;
    check("byte accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulseStart(input bit useB);
    if (useB) bStart = 1'b1; else aStart = 1'b1;
    tick();
    bStart = 1'b0;
    aStart = 1'b0;
  endtask

  // Sixteen bytes b, b+1, ... with stalls; optionally a stray start mid-word.
  task automatic loadB(input logic [7:0] b, input bit strayStart);
    for (int i = 0; i < 16; i++) begin
      sendByte(1'b1, b + 8'(i), gapTab[i]);
      if (strayStart && i == 5) begin
        pulseStart(1'b1);
        check("B ready after stray start", {31'd0, bReady}, 32'd1);
        check("B busy after stray start", {31'd0, bBusy}, 32'd1);
      end
    end
  endtask

  task automatic checkB(input int first, input int count, input logic [7:0] b);
    logic [7:0] x;
    check("B strobe count", bAdrQ.size(), first + count);
    for (int i = 0; i < count; i++) begin
      x = b + 8'(4 * i);
      check("B address", (first + i < bAdrQ.size()) ? bAdrQ[first + i] : 32'hDEAD_DEAD,
            32'h100 + 32'(4 * i));
      check("B word", (first + i < bDatQ.size()) ? bDatQ[first + i] : 32'hDEAD_DEAD,
            {x + 8'd3, x + 8'd2, x + 8'd1, x});
    end
  endtask

  initial begin
    aReset = 1'b1; aStart = 1'b0; aValid = 1'b0; aData = '0;
    bReset = 1'b1; bStart = 1'b0; bValid = 1'b0; bData = '0;
    tick();
    tick();
    check("A reset cpu_reset", {31'd0, aCpuReset}, 32'd1);
    check("A reset byte_ready", {31'd0, aReady}, 32'd0);
    check("A reset Ext_DataAdr", aDataAdr, 32'h0);
    check("B reset Ext_DataAdr", bDataAdr, 32'h100);
    check("B reset Ext_WriteData", bWriteData, 32'h0);
    check("B reset busy/done", {30'd0, bBusy, bDone}, 32'd0);
    aReset = 1'b0;
    bReset = 1'b0;
    repeat (3) tick();
    check("A idle cpu_reset", {31'd0, aCpuReset}, 32'd1);
    check("A idle byte_ready", {31'd0, aReady}, 32'd0);
    check("A idle no strobe", aStrobes, 0);
    check("B idle no strobe", bAdrQ.size(), 0);

    // Single word on A
    pulseStart(1'b0);
    check("A collect ready/busy", {30'd0, aReady, aBusy}, 32'd3);
    sendByte(1'b0, 8'h78, 0);
    sendByte(1'b0, 8'h56, 0);
    sendByte(1'b0, 8'h34, 0);
    sendByte(1'b0, 8'h12, 0);
    check("A strobe", {31'd0, aMemWrite}, 32'd1);
    check("A write data", aWriteData, 32'h1234_5678);
    check("A write addr", aDataAdr, 32'h0);
    check("A ready during write", {31'd0, aReady}, 32'd0);
    check("A cpu_reset during write", {31'd0, aCpuReset}, 32'd1);
    tick();
    check("A done", {31'd0, aDone}, 32'd1);
    check("A cpu released", {31'd0, aCpuReset}, 32'd0);
    check("A strobe ended", {31'd0, aMemWrite}, 32'd0);
    check("A busy in done", {31'd0, aBusy}, 32'd0);
    aValid = 1'b1; aData = 8'hEE;
    repeat (6) tick();
    aValid = 1'b0;
    check("A bytes ignored in done", {31'd0, aReady}, 32'd0);
    check("A strobe count", aStrobes, 1);
    check("A data held", aWriteData, 32'h1234_5678);

    // Restart A from DONE
    pulseStart(1'b0);
    check("A restart cpu_reset", {31'd0, aCpuReset}, 32'd1);
    check("A restart done", {31'd0, aDone}, 32'd0);
    sendByte(1'b0, 8'hDD, 1);
    sendByte(1'b0, 8'hCC, 0);
    sendByte(1'b0, 8'hBB, 2);
    sendByte(1'b0, 8'hAA, 0);
    check("A reload data", aWriteData, 32'hAABB_CCDD);
    check("A reload addr", aDataAdr, 32'h0);
    tick();
    check("A reload done", {31'd0, aDone}, 32'd1);
    check("A total strobes", aStrobes, 2);

    // Multi-word with stalls and a stray start on B
    pulseStart(1'b1);
    loadB(8'h10, 1'b1);
    check("B last strobe addr", bDataAdr, 32'h10C);
    check("B cpu_reset before done", {31'd0, bCpuReset}, 32'd1);
    tick();
    check("B done", {31'd0, bDone}, 32'd1);
    check("B cpu released", {31'd0, bCpuReset}, 32'd0);
    checkB(0, 4, 8'h10);

    // Restart B, then reset mid-load after two bytes of the third word
    bAdrQ.delete();
    bDatQ.delete();
    pulseStart(1'b1);
    check("B restart cpu_reset/done", {30'd0, bCpuReset, bDone}, 32'd2);
    for (int i = 0; i < 10; i++) sendByte(1'b1, 8'h40 + 8'(i), i % 2);
    bReset = 1'b1;
    tick();
    tick();
    check("B midload reset values", {28'd0, bCpuReset, bReady, bBusy, bDone}, 32'h8);
    check("B midload reset addr", bDataAdr, 32'h100);
    check("B midload reset data", bWriteData, 32'h0);
    bReset = 1'b0;
    repeat (4) tick();
    checkB(0, 2, 8'h40);

    bAdrQ.delete();
    bDatQ.delete();
    pulseStart(1'b1);
    loadB(8'h80, 1'b0);
    tick();
    check("B reload done", {31'd0, bDone}, 32'd1);
    checkB(0, 4, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
